// File: rtl/alu_in_pkg.sv
// Shared types and LED codes for the ALU operand entry sequencer.
package alu_in_pkg;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        READY   = 2'd3
    } loader_state_t;

    localparam logic [1:0] LED_WAIT_A  = 2'd0;
    localparam logic [1:0] LED_WAIT_B  = 2'd1;
    localparam logic [1:0] LED_WAIT_OP = 2'd2;
    localparam logic [1:0] LED_READY   = 2'd3;

endpackage

// File: rtl/alu_operand_loader_rise_detect.sv
// Single-pulse rising-edge detector for level (button) inputs.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_in,
    output logic pulse_out
);

    logic r_level_q;

    // Flop resets high so a level held through reset is not seen as a press.
    always_ff @(posedge clk) begin
        if (reset) r_level_q <= 1'b1;
        else       r_level_q <= level_in;
    end

    assign pulse_out = level_in & ~r_level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequences A, B and opcode entry from a shared bus into held ALU operand registers.
//   state   | meaning
//   WAIT_A  | next press captures operand A
//   WAIT_B  | next press captures operand B
//   WAIT_OP | next press captures opcode, completes a set
//   READY   | full set held; next press starts a new set with A
module alu_operand_loader
    import alu_in_pkg::*;
#(
    parameter int width     = 4,
    parameter int op_width  = 4,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [width-1:0]     data_in,
    input  logic                 load,
    input  logic                 clear,
    output logic [width-1:0]     a_out,
    output logic [width-1:0]     b_out,
    output logic [op_width-1:0]  op_out,
    output logic                 valid_out,
    output logic [1:0]           state_out,
    output logic [cnt_width-1:0] op_count
);

    loader_state_t         r_state;
    loader_state_t         w_next_state;
    logic                  w_load_edge;
    logic [width-1:0]      r_a;
    logic [width-1:0]      r_b;
    logic [op_width-1:0]   r_op;
    logic                  r_valid;
    logic [cnt_width-1:0]  r_count;

    rise_detect u_load_edge (
        .clk       (clk),
        .reset     (reset),
        .level_in  (load),
        .pulse_out (w_load_edge)
    );

    always_comb begin
        w_next_state = r_state;
        if (w_load_edge) begin
            case (r_state)
                WAIT_A:  w_next_state = WAIT_B;
                WAIT_B:  w_next_state = WAIT_OP;
                WAIT_OP: w_next_state = READY;
                READY:   w_next_state = WAIT_B;
                default: w_next_state = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else if (clear) begin
            // Abort keeps the completed-set count.
            r_state <= WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= (w_next_state == READY);
            if (w_load_edge) begin
                case (r_state)
                    WAIT_A, READY: r_a <= data_in;
                    WAIT_B:        r_b <= data_in;
                    WAIT_OP: begin
                        r_op    <= data_in[op_width-1:0];
                        r_count <= r_count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign op_out    = r_op;
    assign valid_out = r_valid;
    assign state_out = r_state;
    assign op_count  = r_count;

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Input-side counterpart of the ALU output register stage.
- Sequences operand entry from a shared data bus (board switches) into three held registers: operand A, operand B and ALU opcode.
- Drives the combinational ALU and flags when a complete operand set is present.
- Captures on posedge clk, so the ALU settles for half a cycle before the negedge output register samples it.

Parameters:
- width, 4, operand width for A, B and data_in.
- op_width, 4, opcode width. Must satisfy op_width <= width; the opcode is taken from data_in[op_width-1:0].
- cnt_width, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  width  shared entry bus for A, B and opcode.
- load  input  1  level request (button); the rising edge is the capture event.
- clear  input  1  synchronous abort back to the A-entry state.
- a_out  output  width  held operand A to the ALU.
- b_out  output  width  held operand B to the ALU.
- op_out  output  op_width  held opcode to the ALU.
- valid_out  output  1  high while a complete A/B/op set is held.
- state_out  output  2  current state encoding, for LEDs.
- op_count  output  cnt_width  number of completed operand sets.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - a_out, b_out, op_out, valid_out and op_count are all 0.
  - State is WAIT_A (state_out = 0).
  - Internal load_q is 1, so a load held through reset produces no capture.
- Edge detect:
  - load_q <= load every cycle.
  - load_edge = load & ~load_q.
  - Exactly one capture per press; holding load high produces no repeats. Latency from the load rise to the register update is 1 posedge.
- States (2-bit encoding):
  - WAIT_A = 0. On load_edge: a_out <= data_in; go to WAIT_B.
  - WAIT_B = 1. On load_edge: b_out <= data_in; go to WAIT_OP.
  - WAIT_OP = 2. On load_edge: op_out <= data_in[op_width-1:0]; go to READY; op_count <= op_count + 1.
  - READY = 3. valid_out = 1. On load_edge: a_out <= data_in; go to WAIT_B. The next set is entered without a separate clear.
  - With no load_edge, the state holds.
- valid_out:
  - Registered. Equals 1 exactly when state == READY.
  - Rises on the same posedge that op_out is captured; falls on the posedge that leaves READY.
- Operand stability:
  - a_out, b_out and op_out change only at their own capture edge.
  - Example: b_out keeps its previous value through WAIT_A and until the WAIT_B capture.
- clear:
  - Priority below reset, above load.
  - State goes to WAIT_A; a_out, b_out, op_out and valid_out go to 0.
  - op_count is kept.
  - load_q still tracks load, so an edge coincident with clear is discarded, not deferred.
- op_count:
  - Wraps modulo 2^cnt_width (255 -> 0 at the default).
  - Changes only on the WAIT_OP capture.
- Reset mid-sequence (for example in WAIT_OP) discards any partial entry immediately.
- Boundary cases:
  - data_in changing in the same cycle as load_edge: the value sampled at that posedge is captured.
  - Upper bits data_in[width-1:op_width] are ignored in WAIT_OP.

Decomposition:
- Package alu_in_pkg:
  - typedef enum logic [1:0] loader_state_t {WAIT_A, WAIT_B, WAIT_OP, READY};
  - Constants for state_out LED codes.
- Sub-module rise_detect (clk, reset, level_in, pulse_out):
  - Holds load_q.
  - Reset value of the internal flop is 1.
  - Reused later for other button inputs.
- The FSM and operand registers are in the top module, using always_ff plus an always_comb next-state block.

Test Plan:
- Reset then idle 5 cycles -> a/b/op_out = 0, valid_out = 0, state_out = 0, op_count = 0.
- Press load with data_in = 4'h3, then 4'h5, then 4'h1 (one press each) -> a_out = 3, b_out = 5, op_out = 1, valid_out = 1 on the cycle after the third edge, op_count = 1.
- Hold load high 10 cycles with data_in = 4'h7 from WAIT_A -> exactly one capture (a_out = 7, state WAIT_B); no advance until load falls and rises again.
- In READY, press load with data_in = 4'hA -> a_out = A, state WAIT_B, valid_out = 0 next cycle, b_out and op_out unchanged.
- Assert clear in WAIT_OP with a simultaneous load rise -> state WAIT_A, outputs 0, op_count unchanged, no capture.
- Hold load high through reset deassertion -> no capture on the first cycle. Run 256 complete sets -> op_count wraps to 0.
